// File: rtl/multicycle_controller.sv
// ============================================================================
//  Module   : multicycle_controller
//  Function : RV32I multi-cycle sequencer for a single unified memory port
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
    S_JALR2 = 4'd12, S_LUI = 4'd13, S_AUIPC = 4'd14, S_TRAP = 4'd15
  } state_t;

  localparam logic [3:0] c_add = 4'd0, c_sub = 4'd1, c_sll = 4'd2, c_srl = 4'd3,
                         c_sra = 4'd4, c_slt = 4'd5, c_sltu = 4'd6, c_xor = 4'd7,
                         c_or = 4'd8, c_and = 4'd9;
  localparam logic [2:0] c_imm_i = 3'd0, c_imm_s = 3'd1, c_imm_b = 3'd2,
                         c_imm_j = 3'd3, c_imm_u = 3'd4;
  localparam logic [TO_W-1:0] c_wait_limit = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state, w_next;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_illegal, r_bus_error;
  logic            w_timeout;
  logic            w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
  logic            w_reg_write, w_instr_done;
  logic [1:0]      w_result_src, w_alu_src_a, w_alu_src_b;
  logic [3:0]      w_alu_control;
  logic [2:0]      w_imm_src;

  always_comb begin
    w_next        = r_state;
    w_timeout     = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_instr_done  = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_alu_control = c_add;
    w_imm_src     = c_imm_i;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_alu_src_b  = 2'b10;
          w_result_src = 2'b10;
          w_next       = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = (opcode == 7'b1101111) ? c_imm_j : c_imm_b;
        case (opcode)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          7'b1100111:             w_next = S_JALR;
          7'b0110111:             w_next = S_LUI;
          7'b0010111:             w_next = S_AUIPC;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = (opcode == 7'b0000011) ? c_imm_i : c_imm_s;
        w_next      = (opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_next      = S_ALUWB;
        case ({funct7, funct3})
          10'b0000000_000: w_alu_control = c_add;
          10'b0100000_000: w_alu_control = c_sub;
          10'b0000000_001: w_alu_control = c_sll;
          10'b0000000_010: w_alu_control = c_slt;
          10'b0000000_011: w_alu_control = c_sltu;
          10'b0000000_100: w_alu_control = c_xor;
          10'b0000000_101: w_alu_control = c_srl;
          10'b0100000_101: w_alu_control = c_sra;
          10'b0000000_110: w_alu_control = c_or;
          10'b0000000_111: w_alu_control = c_and;
          default:         w_next = S_TRAP;
        endcase
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = S_ALUWB;
        case (funct3)
          3'b000: w_alu_control = c_add;
          3'b010: w_alu_control = c_slt;
          3'b011: w_alu_control = c_sltu;
          3'b100: w_alu_control = c_xor;
          3'b110: w_alu_control = c_or;
          3'b111: w_alu_control = c_and;
          3'b001: begin
            if (funct7 == 7'b0000000) w_alu_control = c_sll;
            else                      w_next = S_TRAP;
          end
          default: begin
            if (funct7 == 7'b0000000)      w_alu_control = c_srl;
            else if (funct7 == 7'b0100000) w_alu_control = c_sra;
            else                           w_next = S_TRAP;
          end
        endcase
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = 2'b10;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
        case (funct3)
          3'b000: begin w_alu_control = c_sub;  w_pc_write = zero;  end
          3'b001: begin w_alu_control = c_sub;  w_pc_write = !zero; end
          3'b100: begin w_alu_control = c_slt;  w_pc_write = !zero; end
          3'b101: begin w_alu_control = c_slt;  w_pc_write = zero;  end
          3'b110: begin w_alu_control = c_sltu; w_pc_write = !zero; end
          3'b111: begin w_alu_control = c_sltu; w_pc_write = zero;  end
          default: begin
            w_instr_done = 1'b0;
            w_next       = S_TRAP;
          end
        endcase
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      // rd written first; rs1 was already latched into register A in DECODE
      S_JALR: begin
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_reg_write  = 1'b1;
        w_next       = S_JALR2;
      end
      S_JALR2: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_LUI: begin
        w_alu_src_a = 2'b11;
        w_alu_src_b = 2'b01;
        w_imm_src   = c_imm_u;
        w_next      = S_ALUWB;
      end
      S_AUIPC: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = c_imm_u;
        w_next      = S_ALUWB;
      end
      default: w_next = S_TRAP;
    endcase
    // a ready response on the limit cycle never reaches here: only stalled cycles time out
    if ((MEM_TIMEOUT != 0) && w_mem_req && !mem_ready && (r_wait_cnt == c_wait_limit)) begin
      w_timeout = 1'b1;
      w_next    = S_TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_wait_cnt  <= '0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_timeout) r_bus_error <= 1'b1;
      if ((w_next != r_state) &&
          ((w_next == S_FETCH) || (w_next == S_MEMREAD) || (w_next == S_MEMWRITE)))
        r_wait_cnt <= '0;
      else if (w_mem_req && !mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign mem_req     = !reset && w_mem_req;
  assign mem_write   = !reset && w_mem_write;
  assign adr_src     = !reset && w_adr_src;
  assign ir_write    = !reset && w_ir_write;
  assign pc_write    = !reset && w_pc_write;
  assign reg_write   = !reset && w_reg_write;
  assign instr_done  = !reset && w_instr_done;
  assign illegal     = !reset && r_illegal;
  assign bus_error   = !reset && r_bus_error;
  assign result_src  = reset ? 2'b00 : w_result_src;
  assign alu_src_a   = reset ? 2'b00 : w_alu_src_a;
  assign alu_src_b   = reset ? 2'b00 : w_alu_src_b;
  assign alu_control = reset ? 4'd0  : w_alu_control;
  assign imm_src     = reset ? 3'd0  : w_imm_src;
  assign state       = reset ? 4'd0  : r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
//  Module   : tb_multicycle_controller
//  Function : directed self-checking bench for multicycle_controller
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic       instr_done, illegal, bus_error;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .instr_done(instr_done),
    .illegal(illegal), .bus_error(bus_error), .state(state)
  );

  wire [25:0] w_act = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                       result_src, alu_src_a, alu_src_b, alu_control, imm_src,
                       instr_done, illegal, bus_error};

  function automatic logic [25:0] ov(
    input logic [3:0] st, input logic req, wr, adr, irw, pcw, rw,
    input logic [1:0] rs, a, b, input logic [3:0] alu, input logic [2:0] imm,
    input logic done, ill, be);
    return {st, req, wr, adr, irw, pcw, rw, rs, a, b, alu, imm, done, ill, be};
  endfunction

  // Inputs are set right after a falling edge; outputs are checked 1 time unit later
  task automatic cyc(input string tag, input logic [25:0] exp);
    #1;
    n_checks++;
    assert (w_act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, w_act, exp);
    end
    @(negedge clk);
  endtask

  task automatic set_ins(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[31:25];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc("reset_outputs_zero", 26'd0);
    reset = 1'b0;
  endtask

  logic [25:0] f_rdy, f_wait, dec_b, alu_wb, trap_st;

  initial begin
    f_rdy   = ov(4'd0, 1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 4'd0, 3'd0, 0, 0, 0);
    f_wait  = ov(4'd0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 0, 0);
    dec_b   = ov(4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 3'd2, 0, 0, 0);
    alu_wb  = ov(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 1, 0, 0);
    trap_st = ov(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 1, 0);

    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    @(negedge clk);
    do_reset();
    mem_ready = 1'b1;

    // add x3,x1,x2
    set_ins(32'h002081B3);
    cyc("add_fetch", f_rdy);
    cyc("add_decode", dec_b);
    cyc("add_execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd0, 3'd0, 0, 0, 0));
    cyc("add_aluwb", alu_wb);

    // lw x5,8(x1) with three stalled cycles
    set_ins(32'h0080A283);
    cyc("lw_fetch", f_rdy);
    cyc("lw_decode", dec_b);
    cyc("lw_memadr", ov(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'd0, 0, 0, 0));
    mem_ready = 1'b0;
    repeat (3) cyc("lw_memread_wait", ov(4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 0, 0));
    mem_ready = 1'b1;
    cyc("lw_memread_ready", ov(4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 0, 0));
    cyc("lw_memwb", ov(4'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'd0, 3'd0, 1, 0, 0));

    // sw x2,4(x1)
    set_ins(32'h0020A223);
    cyc("sw_fetch", f_rdy);
    cyc("sw_decode", dec_b);
    cyc("sw_memadr", ov(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'd1, 0, 0, 0));
    cyc("sw_memwrite", ov(4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 1, 0, 0));

    // beq taken then not taken
    set_ins(32'h00208463);
    zero = 1'b1;
    cyc("beq_t_fetch", f_rdy);
    cyc("beq_t_decode", dec_b);
    cyc("beq_t_branch", ov(4'd9, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 4'd1, 3'd0, 1, 0, 0));
    zero = 1'b0;
    cyc("beq_n_fetch", f_rdy);
    cyc("beq_n_decode", dec_b);
    cyc("beq_n_branch", ov(4'd9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 3'd0, 1, 0, 0));

    // bltu with ALU result nonzero (x1 < x2): taken
    set_ins(32'h0020E463);
    cyc("bltu_fetch", f_rdy);
    cyc("bltu_decode", dec_b);
    cyc("bltu_branch", ov(4'd9, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 4'd6, 3'd0, 1, 0, 0));

    // jal x1,8
    set_ins(32'h008000EF);
    cyc("jal_fetch", f_rdy);
    cyc("jal_decode", ov(4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 3'd3, 0, 0, 0));
    cyc("jal_jal", ov(4'd10, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 4'd0, 3'd0, 0, 0, 0));
    cyc("jal_aluwb", alu_wb);

    // jalr x1,0(x1)
    set_ins(32'h000080E7);
    cyc("jalr_fetch", f_rdy);
    cyc("jalr_decode", dec_b);
    cyc("jalr_jalr", ov(4'd11, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 4'd0, 3'd0, 0, 0, 0));
    cyc("jalr_jalr2", ov(4'd12, 0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b01, 4'd0, 3'd0, 1, 0, 0));

    // srai x1,x1,3
    set_ins(32'h4030D093);
    cyc("srai_fetch", f_rdy);
    cyc("srai_decode", dec_b);
    cyc("srai_execi", ov(4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd4, 3'd0, 0, 0, 0));
    cyc("srai_aluwb", alu_wb);

    // lui x5,0x12345
    set_ins(32'h123452B7);
    cyc("lui_fetch", f_rdy);
    cyc("lui_decode", dec_b);
    cyc("lui_lui", ov(4'd13, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 4'd0, 3'd4, 0, 0, 0));
    cyc("lui_aluwb", alu_wb);

    // illegal opcode 0x7F: TRAP is sticky whatever the inputs do
    set_ins(32'h0000007F);
    cyc("ill_op_fetch", f_rdy);
    cyc("ill_op_decode", dec_b);
    cyc("ill_op_trap0", trap_st);
    mem_ready = 1'b0;
    cyc("ill_op_trap1", trap_st);
    mem_ready = 1'b1;
    cyc("ill_op_trap2", trap_st);
    do_reset();

    // sub with funct7 = 0100001
    set_ins(32'h422081B3);
    cyc("ill_sub_fetch_flags_clear", f_rdy);
    cyc("ill_sub_decode", dec_b);
    cyc("ill_sub_execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd0, 3'd0, 0, 0, 0));
    cyc("ill_sub_trap", trap_st);
    do_reset();

    // fetch never answered: the 16th stalled cycle times out
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("timeout_fetch_wait", f_wait);
    cyc("timeout_trap", ov(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 1, 1));
    do_reset();

    // reset in the middle of a stalled store
    mem_ready = 1'b1;
    set_ins(32'h0020A223);
    cyc("rst_sw_fetch_flags_clear", f_rdy);
    cyc("rst_sw_decode", dec_b);
    cyc("rst_sw_memadr", ov(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'd1, 0, 0, 0));
    mem_ready = 1'b0;
    cyc("rst_sw_memwrite_wait", ov(4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 0, 0));
    reset = 1'b1;
    cyc("rst_sw_during_reset", 26'd0);
    reset = 1'b0;
    cyc("rst_sw_back_in_fetch", f_wait);
    mem_ready = 1'b1;
    cyc("rst_sw_fetch_ready", f_rdy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
